// File: rtl/hiscore_pkg.sv
// Shared types and defaults for the hiscore upload bridge.
// Holds the bridge state encoding, default parameter values and a sizing helper.
package hiscore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    READY = 2'd2,
    FETCH = 2'd3
  } hs_state_e;

  localparam int         HS_AW_DEF        = 7;
  localparam logic [7:0] UPLOAD_INDEX_DEF = 8'h04;
  localparam logic [7:0] PAD_BYTE_DEF     = 8'hFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hs_rd_timer.sv
// Loadable down-counter with a zero flag; times both the settle window and
// the core read latency. Saturates at zero.
module hs_rd_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Count register: load has priority, otherwise count down until zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/hiscore_upload_bridge.sv
// Serves host ioctl upload reads from the core's hiscore RAM, pausing the core
// for the whole session and stalling the host while each byte is fetched.
module hiscore_upload_bridge
  import hiscore_pkg::*;
#(
  parameter int         HS_AW        = HS_AW_DEF,
  parameter int         RD_LAT       = 2,
  parameter int         SETTLE_CYC   = 16,
  parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEF,
  parameter logic [7:0] PAD_BYTE     = PAD_BYTE_DEF
) (
  input  logic             clk_12,
  input  logic             reset_n,
  input  logic             ioctl_upload,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_rd,
  input  logic [24:0]      ioctl_addr,
  output logic [7:0]       ioctl_din,
  output logic             ioctl_wait,
  output logic [HS_AW-1:0] hs_address,
  input  logic [7:0]       hs_data_out,
  output logic             hs_access,
  output logic             hs_write,
  output logic             pause_o,
  output logic             upload_done
);

  localparam int            CW        = $clog2(max_int(SETTLE_CYC, RD_LAT) + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RD_LD     = CW'(RD_LAT - 1);

  hs_state_e        state_r, state_nx_s;
  logic             upload_q_r;
  logic [7:0]       din_r, din_nx_s;
  logic             wait_r, wait_nx_s;
  logic [HS_AW-1:0] addr_r, addr_nx_s;
  logic             ctl_r, ctl_nx_s;
  logic             done_r, done_nx_s;
  logic             tmr_load_s;
  logic [CW-1:0]    tmr_val_s;
  logic             tmr_zero_s;
  logic             rise_s;
  logic             in_range_s;

  assign rise_s     = ioctl_upload & ~upload_q_r;
  // Full-width compare so high addresses never alias back into the RAM.
  assign in_range_s = (ioctl_addr[24:HS_AW] == {(25-HS_AW){1'b0}});

  hs_rd_timer #(.CW(CW)) u_timer (
    .clk      (clk_12),
    .rst_n    (reset_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and next-output logic; a session drop overrides everything else.
  always_comb begin
    state_nx_s = state_r;
    din_nx_s   = din_r;
    wait_nx_s  = wait_r;
    addr_nx_s  = addr_r;
    ctl_nx_s   = ctl_r;
    done_nx_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CW{1'b0}};
    case (state_r)
      IDLE: begin
        if (rise_s && (ioctl_index == UPLOAD_INDEX)) begin
          state_nx_s = ARM;
          ctl_nx_s   = 1'b1;
          wait_nx_s  = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = SETTLE_LD;
        end else begin
          state_nx_s = IDLE;
          ctl_nx_s   = 1'b0;
          wait_nx_s  = 1'b0;
        end
      end
      ARM: begin
        if (!ioctl_upload) begin
          state_nx_s = IDLE;
          ctl_nx_s   = 1'b0;
          wait_nx_s  = 1'b0;
        end else if (tmr_zero_s) begin
          state_nx_s = READY;
          wait_nx_s  = 1'b0;
        end else begin
          state_nx_s = ARM;
        end
      end
      READY: begin
        if (!ioctl_upload) begin
          state_nx_s = IDLE;
          ctl_nx_s   = 1'b0;
          wait_nx_s  = 1'b0;
        end else if (ioctl_rd && in_range_s) begin
          state_nx_s = FETCH;
          addr_nx_s  = ioctl_addr[HS_AW-1:0];
          wait_nx_s  = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = RD_LD;
        end else if (ioctl_rd) begin
          din_nx_s   = PAD_BYTE;
        end else begin
          state_nx_s = READY;
        end
      end
      FETCH: begin
        if (!ioctl_upload) begin
          state_nx_s = IDLE;
          ctl_nx_s   = 1'b0;
          wait_nx_s  = 1'b0;
        end else if (tmr_zero_s) begin
          state_nx_s = READY;
          din_nx_s   = hs_data_out;
          wait_nx_s  = 1'b0;
          done_nx_s  = &addr_r;
        end else begin
          state_nx_s = FETCH;
        end
      end
      default: begin
        state_nx_s = IDLE;
        ctl_nx_s   = 1'b0;
        wait_nx_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      upload_q_r <= 1'b0;
      din_r      <= 8'h00;
      wait_r     <= 1'b0;
      addr_r     <= {HS_AW{1'b0}};
      ctl_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      upload_q_r <= ioctl_upload;
      din_r      <= din_nx_s;
      wait_r     <= wait_nx_s;
      addr_r     <= addr_nx_s;
      ctl_r      <= ctl_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign ioctl_din   = din_r;
  assign ioctl_wait  = wait_r;
  assign hs_address  = addr_r;
  assign hs_access   = ctl_r;
  assign pause_o     = ctl_r;
  assign upload_done = done_r;
  assign hs_write    = 1'b0;

endmodule

// File: tb/tb_hiscore_upload_bridge.sv
// Directed bench for hiscore_upload_bridge with a one-register core RAM model
// (data valid two edges after hs_address launches, i.e. RD_LAT=2).
module tb_hiscore_upload_bridge;

  logic        clk_12 = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [6:0]  hs_address;
  logic [7:0]  hs_data_out;
  logic        hs_access;
  logic        hs_write;
  logic        pause_o;
  logic        upload_done;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] exp_din = 8'h00;
  logic       hs_write_seen = 1'b0;

  always #5 clk_12 = ~clk_12;

  hiscore_upload_bridge dut (
    .clk_12       (clk_12),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .hs_address   (hs_address),
    .hs_data_out  (hs_data_out),
    .hs_access    (hs_access),
    .hs_write     (hs_write),
    .pause_o      (pause_o),
    .upload_done  (upload_done)
  );

  // Core hiscore RAM model: mem[a] = a ^ 8'h5A behind one register stage.
  always @(posedge clk_12) hs_data_out <= {1'b0, hs_address} ^ 8'h5A;

  always @(negedge clk_12) if (hs_write !== 1'b0) hs_write_seen = 1'b1;

  task automatic test_reset();
    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'h00;
    ioctl_rd = 1'b0; ioctl_addr = 25'd0;
    repeat (2) @(negedge clk_12);
    vec_cnt++;
    if ({ioctl_din, ioctl_wait, hs_address, hs_access, pause_o, upload_done} !== 19'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got din=%h wait=%b addr=%h acc=%b pause=%b done=%b, expected all 0",
               ioctl_din, ioctl_wait, hs_address, hs_access, pause_o, upload_done);
    end
    reset_n = 1'b1;
    @(negedge clk_12);
  endtask

  // Raise a matching session and check the settle window length.
  task automatic test_arm();
    int n;
    ioctl_index = 8'h04; ioctl_upload = 1'b1;
    @(negedge clk_12);
    n = 1;
    vec_cnt++;
    if ({pause_o, hs_access, ioctl_wait} !== 3'b111) begin
      err_cnt++;
      $display("FAIL arm_entry: got pause/acc/wait=%b%b%b expected 111", pause_o, hs_access, ioctl_wait);
    end
    while (ioctl_wait === 1'b1 && n < 60) begin
      @(negedge clk_12);
      n++;
    end
    vec_cnt++;
    if (n != 17) begin
      err_cnt++;
      $display("FAIL arm_settle: wait fell after %0d cycles expected 17", n);
    end
    vec_cnt++;
    if ({pause_o, hs_access} !== 2'b11) begin
      err_cnt++;
      $display("FAIL ready_ctl: got pause/acc=%b%b expected 11", pause_o, hs_access);
    end
  endtask

  // In-range read: wait high for two cycles, data on the third.
  task automatic test_read(input logic [24:0] addr, input logic [7:0] exp, input logic exp_done);
    ioctl_rd = 1'b1; ioctl_addr = addr;
    @(negedge clk_12);
    ioctl_rd = 1'b0;
    vec_cnt++;
    if (ioctl_wait !== 1'b1) begin
      err_cnt++;
      $display("FAIL read_wait1 addr=%h: got %b expected 1", addr, ioctl_wait);
    end
    @(negedge clk_12);
    vec_cnt++;
    if (ioctl_wait !== 1'b1 || upload_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_wait2 addr=%h: got wait=%b done=%b expected 1 0", addr, ioctl_wait, upload_done);
    end
    @(negedge clk_12);
    vec_cnt++;
    if (ioctl_wait !== 1'b0 || ioctl_din !== exp || upload_done !== exp_done) begin
      err_cnt++;
      $display("FAIL read_data addr=%h: got wait=%b din=%h done=%b expected 0 %h %b",
               addr, ioctl_wait, ioctl_din, upload_done, exp, exp_done);
    end
    exp_din = exp;
    @(negedge clk_12);
    vec_cnt++;
    if (upload_done !== 1'b0 || ioctl_din !== exp) begin
      err_cnt++;
      $display("FAIL read_hold addr=%h: got done=%b din=%h expected 0 %h", addr, upload_done, ioctl_din, exp);
    end
  endtask

  // Out-of-range read: pad byte after one cycle, no stall.
  task automatic test_pad(input logic [24:0] addr);
    ioctl_rd = 1'b1; ioctl_addr = addr;
    @(negedge clk_12);
    ioctl_rd = 1'b0;
    vec_cnt++;
    if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || upload_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL pad addr=%h: got din=%h wait=%b done=%b expected ff 0 0",
               addr, ioctl_din, ioctl_wait, upload_done);
    end
    exp_din = 8'hFF;
    @(negedge clk_12);
  endtask

  // Drop the session mid-fetch, then re-arm and read again.
  task automatic test_abort();
    int n;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    @(negedge clk_12);
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk_12);
    vec_cnt++;
    if ({pause_o, hs_access, ioctl_wait} !== 3'b000 || ioctl_din !== exp_din) begin
      err_cnt++;
      $display("FAIL abort: got ctl=%b%b%b din=%h expected 000 %h",
               pause_o, hs_access, ioctl_wait, ioctl_din, exp_din);
    end
    @(negedge clk_12);
    ioctl_upload = 1'b1;
    @(negedge clk_12);
    vec_cnt++;
    if ({pause_o, hs_access, ioctl_wait} !== 3'b111) begin
      err_cnt++;
      $display("FAIL rearm: got ctl=%b%b%b expected 111", pause_o, hs_access, ioctl_wait);
    end
    n = 1;
    while (ioctl_wait === 1'b1 && n < 60) begin
      @(negedge clk_12);
      n++;
    end
    vec_cnt++;
    if (n != 17) begin
      err_cnt++;
      $display("FAIL rearm_settle: wait fell after %0d cycles expected 17", n);
    end
    test_read(25'h01, 8'h5B, 1'b0);
  endtask

  // Read strobe coincident with the session drop is discarded.
  task automatic test_rd_fall();
    ioctl_rd = 1'b1; ioctl_addr = 25'h03; ioctl_upload = 1'b0;
    @(negedge clk_12);
    ioctl_rd = 1'b0;
    repeat (3) begin
      vec_cnt++;
      if ({pause_o, hs_access, ioctl_wait, upload_done} !== 4'b0000 || ioctl_din !== exp_din
          || hs_address !== 7'h01) begin
        err_cnt++;
        $display("FAIL rd_fall: got ctl=%b%b%b done=%b din=%h addr=%h expected 0000 %h 01",
                 pause_o, hs_access, ioctl_wait, upload_done, ioctl_din, hs_address, exp_din);
      end
      @(negedge clk_12);
    end
  endtask

  // Foreign index is ignored; then async reset mid-ARM.
  task automatic test_ignored_session();
    ioctl_index = 8'h00; ioctl_upload = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ioctl_rd = (i == 8 || i == 15) ? 1'b1 : 1'b0;
      ioctl_addr = (i == 15) ? 25'h90 : 25'h07;
      @(negedge clk_12);
      vec_cnt++;
      if ({pause_o, hs_access, ioctl_wait, upload_done} !== 4'b0000 || ioctl_din !== exp_din
          || hs_address !== 7'h01) begin
        err_cnt++;
        $display("FAIL ignored_session cycle %0d: got ctl=%b%b%b done=%b din=%h addr=%h expected 0000 %h 01",
                 i, pause_o, hs_access, ioctl_wait, upload_done, ioctl_din, hs_address, exp_din);
      end
    end
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_12);
    ioctl_index = 8'h04; ioctl_upload = 1'b1;
    repeat (4) @(negedge clk_12);
    vec_cnt++;
    if (pause_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_arm: got pause=%b expected 1", pause_o);
    end
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({ioctl_din, ioctl_wait, hs_address, hs_access, pause_o, upload_done} !== 19'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got din=%h wait=%b addr=%h acc=%b pause=%b done=%b expected all 0",
               ioctl_din, ioctl_wait, hs_address, hs_access, pause_o, upload_done);
    end
    exp_din = 8'h00;
    @(negedge clk_12);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_12);
    reset_n = 1'b1;
    @(negedge clk_12);
  endtask

  // Stream the whole RAM honouring ioctl_wait.
  task automatic test_back_to_back();
    int n;
    int g;
    ioctl_index = 8'h04; ioctl_upload = 1'b1;
    @(negedge clk_12);
    n = 1;
    while (ioctl_wait === 1'b1 && n < 60) begin
      @(negedge clk_12);
      n++;
    end
    vec_cnt++;
    if (n != 17) begin
      err_cnt++;
      $display("FAIL stream_settle: wait fell after %0d cycles expected 17", n);
    end
    for (int a = 0; a < 128; a++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(a);
      @(negedge clk_12);
      ioctl_rd = 1'b0;
      g = 0;
      while (ioctl_wait === 1'b1 && g < 10) begin
        @(negedge clk_12);
        g++;
      end
      vec_cnt++;
      if (g != 2 || ioctl_din !== (8'(a) ^ 8'h5A) || upload_done !== (a == 127)) begin
        err_cnt++;
        $display("FAIL stream addr=%h: got stall=%0d din=%h done=%b expected 2 %h %b",
                 a, g, ioctl_din, upload_done, 8'(a) ^ 8'h5A, (a == 127));
      end
    end
    vec_cnt++;
    if (hs_write_seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL hs_write: got a nonzero hs_write expected constant 0");
    end
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_12);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_read(25'h05, 8'h5F, 1'b0);
    test_read(25'h7F, 8'h25, 1'b1);
    test_pad(25'h80);
    test_pad(25'h1000000);
    test_abort();
    test_rd_fall();
    test_ignored_session();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
